axi_slave_wr_ctrl: RTL and testbench

AXI4 slave-side write controller for the slave wrappers behind the interconnect (IM, DM, DRAM/ROM bridge, peripheral slots). It accepts one write burst at a time on AW/W, drives a word-addressed SRAM-style write port, and generates the B response with the 8-bit slave-side ID echoed back. Its BVALID/BID/BRESP outputs feed the interconnect's write-response arbiter, which routes them to the originating master using BID[5:4].

---
 rtl/axi_slave_wr_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_axi_slave_wr_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_ctrl.sv
// ---------------------------------------------------------------------------
// axi_slave_wr_ctrl
//
// AXI4 slave-side write controller. Accepts one write burst at a time on the
// AW/W channels, drives a word-addressed SRAM-style write port with zero
// latency relative to each W handshake, and returns a B response echoing the
// 8-bit slave-side ID ({master select[5:4], master ID[3:0]}).
//
// Optional feature (compile-time macro):
//   WLAST_CHECK_EN - when defined, a WLAST that disagrees with the beat count
//                    on any beat sets the error flag (BRESP = SLVERR). The
//                    burst still ends on the beat count. When undefined, WLAST
//                    is ignored.
//
// Parameters:
//   MEM_AW     word-address width of the memory port (default 14)
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WLAST/WVALID/WREADY                    write data channel
//   BID/BRESP/BVALID/BREADY                            write response channel
//   mem_cs     memory select, high only on a W handshake with any strobe set
//   mem_we     byte write enables (WSTRB during a W handshake, else 0)
//   mem_addr   word address of the current beat (0 outside a handshake)
//   mem_wdata  write data of the current beat (0 outside a handshake)
// ---------------------------------------------------------------------------
module axi_slave_wr_ctrl #(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [7:0]        BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WRESP = 2'd2
  } state_t;

  // Control state (reset)
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              bvalid_q, bvalid_d;
  logic [7:0]        bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  // Burst context captured at the AW handshake (no reset needed: only
  // observed while a burst is active)
  logic [7:0]        id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;
  logic wlast_err;

  assign aw_hs     = AWVALID & (state_q == S_IDLE);
  assign w_hs      = WVALID  & (state_q == S_WDATA);
  assign b_hs      = bvalid_q & BREADY;
  assign last_beat = (cnt_q == len_q);

`ifdef WLAST_CHECK_EN
  // WLAST must be high exactly on the beat where the count reaches AWLEN.
  assign wlast_err = w_hs & (WLAST != last_beat);
  logic unused_in;
  assign unused_in = ^{AWSIZE, AWADDR[31:MEM_AW+2], AWADDR[1:0]};
`else
  assign wlast_err = 1'b0;
  // AWSIZE is treated as word size regardless; WLAST is not consulted.
  logic unused_in;
  assign unused_in = ^{AWSIZE, AWADDR[31:MEM_AW+2], AWADDR[1:0], WLAST};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    burst_d  = burst_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d    = AWID;
          addr_d  = AWADDR[MEM_AW+1:2];
          len_d   = AWLEN;
          burst_d = AWBURST;
          cnt_d   = 4'd0;
          // WRAP runs as INCR but is reported as an error.
          err_d   = (AWBURST == BURST_WRAP);
          state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        if (w_hs) begin
          err_d = err_q | wlast_err;
          if (last_beat) begin
            state_d  = S_WRESP;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q | wlast_err) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            cnt_d = cnt_q + 4'd1;
            // Natural overflow gives the modulo-2^MEM_AW wrap.
            if (burst_q != BURST_FIXED) begin
              addr_d = addr_q + ADDR_ONE;
            end
          end
        end
      end
      S_WRESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        bvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= 8'd0;
      bresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q    <= id_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    burst_q <= burst_d;
  end

  assign AWREADY = (state_q == S_IDLE);
  assign WREADY  = (state_q == S_WDATA);
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;

  // Memory port is live only during a W handshake; async reset drops the
  // FSM out of WDATA and so kills any write in progress immediately.
  assign mem_cs    = w_hs & (|WSTRB);
  assign mem_we    = w_hs ? WSTRB  : 4'd0;
  assign mem_addr  = w_hs ? addr_q : '0;
  assign mem_wdata = w_hs ? WDATA  : 32'd0;

endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_wr_ctrl
//
// Drives directed and randomized write bursts into axi_slave_wr_ctrl. A
// transaction-level model (phase idle / data / response, beats remaining,
// current word address, error flag) predicts every output on each falling
// edge; directed bursts additionally pin specific literal values.
// ---------------------------------------------------------------------------
module tb_axi_slave_wr_ctrl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    AWID;
  logic [31:0]   AWADDR;
  logic [3:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WLAST;
  logic          WVALID;
  logic          WREADY;
  logic [7:0]    BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic          mem_cs;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  axi_slave_wr_ctrl #(.MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction-level reference model, checked every falling edge.
  // ph: 0 = waiting for AW, 1 = taking W beats, 2 = response pending.
  // ------------------------------------------------------------------
  int            ph = 0;
  int            m_left;
  logic [7:0]    m_id;
  logic [AW-1:0] m_addr;
  logic          m_fixed;
  logic          m_err;
  logic [1:0]    m_resp;

  always @(negedge clk) begin
    if (rst) begin
      ph = 0;
      chk("rst_awready", AWREADY, 1);
      chk("rst_wready", WREADY, 0);
      chk("rst_bvalid", BVALID, 0);
      chk("rst_bid", BID, 0);
      chk("rst_bresp", BRESP, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end else begin
      chk("awready", AWREADY, ph == 0);
      chk("wready", WREADY, ph == 1);
      chk("bvalid", BVALID, ph == 2);
      if (ph == 2) begin
        chk("bid", BID, m_id);
        chk("bresp", BRESP, m_resp);
      end
      if (ph == 1 && WVALID) begin
        chk("mem_cs", mem_cs, |WSTRB);
        chk("mem_we", mem_we, WSTRB);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, WDATA);
      end else begin
        chk("mem_cs_idle", mem_cs, 0);
        chk("mem_we_idle", mem_we, 0);
      end
      // Predict the effect of the coming rising edge.
      if (ph == 0) begin
        if (AWVALID) begin
          ph      = 1;
          m_id    = AWID;
          m_addr  = AWADDR[AW+1:2];
          m_left  = int'(AWLEN) + 1;
          m_fixed = (AWBURST == 2'b00);
          m_err   = (AWBURST == 2'b10);
        end
      end else if (ph == 1) begin
        if (WVALID) begin
`ifdef WLAST_CHECK_EN
          if (WLAST != (m_left == 1)) m_err = 1'b1;
`endif
          if (m_left == 1) begin
            ph     = 2;
            m_resp = m_err ? 2'b10 : 2'b00;
          end else begin
            m_left = m_left - 1;
            if (!m_fixed) m_addr = m_addr + 14'd1;
          end
        end
      end else begin
        if (BREADY) ph = 0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Drivers. Inputs change 1 time unit after the rising edge; handshakes
  // are detected on the falling edge before the edge that completes them.
  // ------------------------------------------------------------------
  logic [AW-1:0] s_addr;
  logic [3:0]    s_we;
  logic          s_cs;
  logic [7:0]    s_bid;
  logic [1:0]    s_bresp;
  int            s_bwait;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] a,
                       input logic [3:0] len, input logic [1:0] b, input int dly);
    logic ok;
    AWVALID = 1'b0;
    repeat (dly) cyc();
    AWID = id; AWADDR = a; AWLEN = len; AWBURST = b; AWSIZE = 3'b010;
    AWVALID = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = AWVALID && AWREADY;
      cyc();
    end
    AWVALID = 1'b0;
    if (!ok) chk("aw_timeout", 0, 1);
  endtask

  task automatic do_beat(input logic [31:0] d, input logic [3:0] s,
                         input logic last, input int gap);
    logic ok;
    WVALID = 1'b0;
    repeat (gap) cyc();
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = WVALID && WREADY;
      if (ok) begin
        s_addr = mem_addr; s_we = mem_we; s_cs = mem_cs;
      end
      cyc();
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    if (!ok) chk("w_timeout", 0, 1);
  endtask

  task automatic do_b(input int stall);
    logic ok;
    BREADY = 1'b0;
    repeat (stall) cyc();
    BREADY = 1'b1;
    ok = 1'b0;
    s_bwait = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = BVALID && BREADY;
      if (ok) begin
        s_bid = BID; s_bresp = BRESP;
      end else begin
        s_bwait++;
      end
      cyc();
    end
    BREADY = 1'b0;
    if (!ok) chk("b_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3'b010; AWBURST = 0; AWVALID = 0;
    WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Single write: byte 0x10 -> word 4; B echoes 0x21 OKAY one cycle later.
    do_aw(8'h21, 32'h0000_0010, 4'd0, 2'b01, 0);
    do_beat(32'hDEAD_BEEF, 4'hF, 1'b1, 0);
    chk("single_addr", s_addr, 4);
    chk("single_we", s_we, 4'hF);
    chk("single_cs", s_cs, 1);
    do_b(0);
    chk("single_bwait", s_bwait, 0);
    chk("single_bid", s_bid, 8'h21);
    chk("single_bresp", s_bresp, 2'b00);
    chk("single_awready_back", AWREADY, 1);

    // INCR burst of 4 from word 0 with WVALID low every other cycle.
    do_aw(8'h05, 32'h0, 4'd3, 2'b01, 1);
    for (int i = 0; i < 4; i++) begin
      do_beat(32'h1000 + i, 4'hF, i == 3, 1);
      chk("incr_addr", s_addr, i);
    end
    do_b(0);
    chk("incr_bresp", s_bresp, 2'b00);

    // FIXED burst of 3 at word 5.
    do_aw(8'h13, 32'h14, 4'd2, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      do_beat(32'h2000 + i, 4'h3, i == 2, 0);
      chk("fixed_addr", s_addr, 5);
    end
    do_b(0);
    chk("fixed_bresp", s_bresp, 2'b00);

    // INCR from the top word wraps to 0.
    do_aw(8'h3A, 32'h0000_FFFC, 4'd1, 2'b01, 0);
    do_beat(32'hA5A5_0001, 4'hF, 1'b0, 0);
    chk("wrap_first_addr", s_addr, 14'h3FFF);
    do_beat(32'hA5A5_0002, 4'hF, 1'b1, 0);
    chk("wrap_second_addr", s_addr, 0);
    do_b(1);

    // Zero strobes and B backpressure.
    do_aw(8'h24, 32'h0000_0100, 4'd0, 2'b01, 0);
    do_beat(32'h1234_5678, 4'h0, 1'b1, 0);
    chk("zero_strb_cs", s_cs, 0);
    chk("zero_strb_we", s_we, 0);
    do_b(5);
    chk("bp_bwait", s_bwait, 0);
    chk("bp_bid", s_bid, 8'h24);
    chk("bp_bresp", s_bresp, 2'b00);

    // WRAP runs as INCR and reports SLVERR.
    do_aw(8'h17, 32'h0000_0040, 4'd1, 2'b10, 0);
    do_beat(32'h1, 4'hF, 1'b0, 0);
    chk("wrapb_addr0", s_addr, 16);
    do_beat(32'h2, 4'hF, 1'b1, 0);
    chk("wrapb_addr1", s_addr, 17);
    do_b(0);
    chk("wrapb_bresp", s_bresp, 2'b10);

`ifdef WLAST_CHECK_EN
    // WLAST on beat 0 of a 2-beat burst: burst still ends on count, SLVERR.
    do_aw(8'h2C, 32'h0000_0080, 4'd1, 2'b01, 0);
    do_beat(32'h3, 4'hF, 1'b1, 0);
    do_beat(32'h4, 4'hF, 1'b1, 0);
    chk("wlast_addr1", s_addr, 33);
    do_b(0);
    chk("wlast_bresp", s_bresp, 2'b10);
`endif

    // Async reset during beat 2 of a 4-beat burst.
    do_aw(8'h11, 32'h0000_0200, 4'd3, 2'b01, 0);
    do_beat(32'h10, 4'hF, 1'b0, 0);
    do_beat(32'h11, 4'hF, 1'b0, 0);
    WDATA = 32'h12; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_bvalid", BVALID, 0);
    chk("arst_awready", AWREADY, 1);
    cyc();
    rst = 1'b0;
    WVALID = 1'b0;
    cyc();
    do_aw(8'h31, 32'h0000_0008, 4'd0, 2'b01, 0);
    do_beat(32'hCAFE_F00D, 4'hC, 1'b1, 0);
    chk("post_rst_addr", s_addr, 2);
    chk("post_rst_we", s_we, 4'hC);
    do_b(0);
    chk("post_rst_bid", s_bid, 8'h31);
    chk("post_rst_bresp", s_bresp, 2'b00);

    // Randomized bursts, checked by the model each cycle.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [3:0]  len;
      logic [1:0]  b;
      logic [3:0]  s;
      a   = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 3) == 0) a = 32'h0000_FFF0 | (a & 32'hC);
      len = 4'($urandom_range(0, 15));
      b   = 2'($urandom_range(0, 2));
      do_aw(8'($urandom), a, len, b, $urandom_range(0, 2));
      for (int i = 0; i <= int'(len); i++) begin
        s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
        do_beat($urandom, s, i == int'(len), $urandom_range(0, 2));
      end
      do_b($urandom_range(0, 3));
    end

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
